// File: rtl/cdb_arbiter_pkg.sv
// Shared CPU types: CDB broadcast record, reservation-station tags and the
// per-FU result bundle consumed by the CDB arbiter.
package cpu_types;

    localparam int CDB_N_FU = 4;

    typedef enum logic [2:0] {
        INVALID  = 3'd0,
        RS_ALU   = 3'd1,
        RS_ALU2  = 3'd2,
        RS_MUL   = 3'd3,
        RS_DIV   = 3'd4,
        RS_LOAD  = 3'd5,
        RS_STORE = 3'd6,
        RS_BR    = 3'd7
    } RS_tag_type;

    typedef struct packed {
        RS_tag_type  tag;
        logic [31:0] data;
    } cdb_t;

    typedef struct packed {
        logic        valid;
        RS_tag_type  tag;
        logic [31:0] data;
    } fu_result_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU-result / CDB bundle: master is the FU side, slave is the arbiter.
interface cdb_arbiter_if import cpu_types::*; #(
    parameter int N_FU  = CDB_N_FU,
    parameter int IDX_W = $clog2(N_FU)
) ();
    logic              flush;
    logic [N_FU-1:0]   fu_valid;
    RS_tag_type        fu_tag  [N_FU];
    logic [31:0]       fu_data [N_FU];
    logic [N_FU-1:0]   fu_ready;
    cdb_t              cdb_out;
    logic [IDX_W-1:0]  cdb_grant_idx;

    modport master (
        output flush, fu_valid, fu_tag, fu_data,
        input  fu_ready, cdb_out, cdb_grant_idx
    );

    modport slave (
        input  flush, fu_valid, fu_tag, fu_data,
        output fu_ready, cdb_out, cdb_grant_idx
    );
endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Round-robin select: first request found after ptr (wrapping) wins.
// Purely combinational so it can be reused for issue-queue select.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_grant
);
    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= N; k++) begin
            // explicit wrap so non-power-of-two N never lands on a missing slot
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDX_W'(cand);
            if (!any_grant && req[cand_idx]) begin
                any_grant       = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// CDB producer: one-entry holding buffer per FU, round-robin grant,
// registered one-cycle broadcast of the winner.
module cdb_arbiter import cpu_types::*; #(
    parameter int N_FU  = CDB_N_FU,
    parameter int IDX_W = $clog2(N_FU)
) (
    input  logic          CLK,
    input  logic          RST_N,
    cdb_arbiter_if.slave  bus
);
    fu_result_t       fu_in [N_FU];

    logic [N_FU-1:0]  buf_v_q, buf_v_d;
    RS_tag_type       buf_tag_q  [N_FU];
    RS_tag_type       buf_tag_d  [N_FU];
    logic [31:0]      buf_data_q [N_FU];
    logic [31:0]      buf_data_d [N_FU];
    logic [IDX_W-1:0] ptr_q, ptr_d;
    cdb_t             cdb_q, cdb_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;

    logic [N_FU-1:0]  grant;
    logic [IDX_W-1:0] grant_idx;
    logic             any_grant;
    logic             take_grant;
    logic [N_FU-1:0]  fu_ready;

    for (genvar gi = 0; gi < N_FU; gi++) begin : g_fu_in
        assign fu_in[gi] = '{valid: bus.fu_valid[gi], tag: bus.fu_tag[gi], data: bus.fu_data[gi]};
    end

    rr_arbiter #(.N(N_FU), .IDX_W(IDX_W)) u_rr (
        .req       (buf_v_q),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // a buffer being granted this cycle can accept its replacement at the same edge
    assign fu_ready   = bus.flush ? '0 : (~buf_v_q | grant);
    assign take_grant = any_grant && !bus.flush;

    assign bus.fu_ready      = fu_ready;
    assign bus.cdb_out       = cdb_q;
    assign bus.cdb_grant_idx = grant_idx_q;

    always_comb begin
        buf_v_d     = buf_v_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        ptr_d       = ptr_q;
        cdb_d       = cdb_q;
        grant_idx_d = grant_idx_q;

        cdb_d.tag = INVALID;
        if (take_grant) begin
            cdb_d       = '{tag: buf_tag_q[grant_idx], data: buf_data_q[grant_idx]};
            grant_idx_d = grant_idx;
            ptr_d       = grant_idx;
        end

        for (int i = 0; i < N_FU; i++) begin
            if (fu_in[i].valid && fu_ready[i] && fu_in[i].tag != INVALID) begin
                buf_v_d[i]    = 1'b1;
                buf_tag_d[i]  = fu_in[i].tag;
                buf_data_d[i] = fu_in[i].data;
            end else if (take_grant && grant[i]) begin
                buf_v_d[i] = 1'b0;
            end
        end

        if (bus.flush) begin
            buf_v_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            buf_v_q     <= '0;
            ptr_q       <= IDX_W'(N_FU - 1);
            cdb_q       <= '{tag: INVALID, data: 32'd0};
            grant_idx_q <= '0;
            for (int i = 0; i < N_FU; i++) begin
                buf_tag_q[i]  <= INVALID;
                buf_data_q[i] <= '0;
            end
        end else begin
            buf_v_q     <= buf_v_d;
            ptr_q       <= ptr_d;
            cdb_q       <= cdb_d;
            grant_idx_q <= grant_idx_d;
            for (int i = 0; i < N_FU; i++) begin
                buf_tag_q[i]  <= buf_tag_d[i];
                buf_data_q[i] <= buf_data_d[i];
            end
        end
    end
endmodule
